// File: rtl/serdes_link_sched.sv
// serdes_link_sched
//   Link-level controller in front of an 8-bit serdes. One byte per slot of
//   HOLD clocks is presented on para_in_o. The link is trained by sending
//   SYNC_WORD until LOCK_COUNT consecutive slot samples of the looped-back
//   para_out_i equal SYNC_WORD. Once locked, the transmit slots are shared
//   round-robin between NREQ byte requesters. A sync byte is forced after
//   every SYNC_PERIOD data bytes, and every received slot is handed upstream.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   retrain      level; forces a return to training
//   req_valid    per-requester byte available
//   req_data     requester i byte at [8i+7:8i]
//   req_ready    one-hot accept pulse, asserted only in the granting slot-end cycle
//   grant_id     index of the last granted requester
//   para_in_o    byte driven to serdes para_in, stable for HOLD cycles
//   para_out_i   byte from serdes para_out
//   locked       link trained
//   rx_data      para_out_i sampled at slot end while locked
//   rx_valid     one-cycle pulse per received slot while locked
//   rx_is_sync   qualifies rx_valid; rx_data == SYNC_WORD
//
// State | meaning
//   TRAIN | sending SYNC_WORD, counting consecutive SYNC_WORD samples
//   RUN   | locked; arbitrating requesters, inserting sync, receiving
module serdes_link_sched #(
    parameter int          NREQ        = 2,
    parameter int          HOLD        = 10,
    parameter logic [7:0]  SYNC_WORD   = 8'h81,
    parameter logic [7:0]  IDLE_WORD   = 8'h00,
    parameter int          SYNC_PERIOD = 16,
    parameter int          LOCK_COUNT  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              retrain,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [2:0]        grant_id,
    output logic [7:0]        para_in_o,
    input  logic [7:0]        para_out_i,
    output logic              locked,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              rx_is_sync
);

    localparam int SW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int DW = $clog2(SYNC_PERIOD + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic {
        TRAIN = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t         state;
    logic [SW-1:0]  slot_cnt;
    logic [DW-1:0]  data_cnt;
    logic [MW-1:0]  match_cnt;
    logic [2:0]     rr_ptr;

    logic           slot_end;
    logic           sync_due;
    logic           sample_is_sync;
    logic           pick_found;
    logic [2:0]     pick_idx;
    logic [7:0]     pick_byte;
    logic           grant_ok;

    assign slot_end       = (slot_cnt == SW'(HOLD - 1));
    assign sync_due       = (data_cnt == DW'(SYNC_PERIOD));
    assign sample_is_sync = (para_out_i == SYNC_WORD);

    // (base + k) mod NREQ; base < NREQ and k < NREQ so one subtraction suffices
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[2:0];
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_byte  = IDLE_WORD;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_found && req_valid[i] && (3'(i) == rr_index(rr_ptr, k))) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(i);
                    pick_byte  = req_data[8*i +: 8];
                end
            end
        end
    end

    // Retrain suppresses the grant in the same cycle so no byte is consumed
    // that will never be sent.
    assign grant_ok = (state == RUN) && slot_end && !retrain && !sync_due && pick_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_ok && (3'(i) == pick_idx);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= TRAIN;
            slot_cnt   <= '0;
            data_cnt   <= '0;
            match_cnt  <= '0;
            rr_ptr     <= '0;
            grant_id   <= '0;
            para_in_o  <= '0;
            locked     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_is_sync <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            rx_is_sync <= 1'b0;
            slot_cnt   <= slot_end ? '0 : slot_cnt + SW'(1);

            if ((state == RUN) && slot_end) begin
                rx_valid   <= 1'b1;
                rx_data    <= para_out_i;
                rx_is_sync <= sample_is_sync;
            end

            if (retrain) begin
                // The current byte completes its slot; the next load is sync.
                state     <= TRAIN;
                locked    <= 1'b0;
                match_cnt <= '0;
                if (slot_end) para_in_o <= SYNC_WORD;
            end else if (state == TRAIN) begin
                if (slot_end) begin
                    para_in_o <= SYNC_WORD;
                    if (sample_is_sync) begin
                        if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                            state     <= RUN;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            data_cnt  <= '0;
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end
            end else if (slot_end) begin
                if (sync_due) begin
                    para_in_o <= SYNC_WORD;
                    data_cnt  <= '0;
                end else if (pick_found) begin
                    para_in_o <= pick_byte;
                    grant_id  <= pick_idx;
                    rr_ptr    <= (pick_idx == 3'(NREQ - 1)) ? 3'd0 : pick_idx + 3'd1;
                    data_cnt  <= data_cnt + DW'(1);
                end else begin
                    // Idle slots do not count toward the sync period.
                    para_in_o <= IDLE_WORD;
                end
            end
        end
    end

endmodule

// File: tb/tb_serdes_link_sched.sv
module tb_serdes_link_sched;

    localparam int         NREQ        = 3;
    localparam int         HOLD        = 4;
    localparam int         SYNC_PERIOD = 4;
    localparam int         LOCK_COUNT  = 3;
    localparam logic [7:0] SYNC        = 8'h81;
    localparam logic [7:0] IDLE        = 8'h00;

    logic              clk;
    logic              reset;
    logic              retrain;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [2:0]        grant_id;
    logic [7:0]        para_in_o;
    logic [7:0]        para_out_i;
    logic              locked;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_is_sync;

    int n_checks;
    int n_pass;

    // reference model: slot position, training progress, data count, pointer
    int              m_slot, m_match, m_data, m_rr, m_grant;
    bit              m_run, m_locked, m_rxv, m_rxs;
    logic [7:0]      m_para, m_rxd;
    logic [NREQ-1:0] e_ready;
    logic [NREQ-1:0] obs_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    serdes_link_sched #(
        .NREQ(NREQ), .HOLD(HOLD), .SYNC_WORD(SYNC), .IDLE_WORD(IDLE),
        .SYNC_PERIOD(SYNC_PERIOD), .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk(clk), .reset(reset), .retrain(retrain),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .grant_id(grant_id), .para_in_o(para_in_o), .para_out_i(para_out_i),
        .locked(locked), .rx_data(rx_data), .rx_valid(rx_valid), .rx_is_sync(rx_is_sync)
    );

    task automatic model_reset();
        m_slot = 0; m_match = 0; m_data = 0; m_rr = 0; m_grant = 0;
        m_run = 0; m_locked = 0; m_rxv = 0; m_rxs = 0;
        m_para = 8'h00; m_rxd = 8'h00;
        e_ready = '0; obs_ready = '0;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // Called at posedge+1 with inputs already driven; returns at posedge+1.
    task automatic tick();
        bit         se, rt;
        int         g;
        logic [7:0] pout, gbyte;
        #2;
        se   = (m_slot == HOLD - 1);
        rt   = retrain;
        pout = para_out_i;
        g    = rr_pick(req_valid, m_rr);
        if (g >= 0) gbyte = req_data[8*g +: 8];
        else        gbyte = IDLE;
        e_ready = '0;
        if (m_run && se && !rt && (m_data != SYNC_PERIOD) && (g >= 0)) e_ready[g] = 1'b1;
        obs_ready = req_ready;
        @(posedge clk);
        m_rxv = 0;
        m_rxs = 0;
        if (m_run && se) begin
            m_rxv = 1; m_rxd = pout; m_rxs = (pout == SYNC);
        end
        if (rt) begin
            if (se) m_para = SYNC;
            m_run = 0; m_locked = 0; m_match = 0;
        end else if (!m_run) begin
            if (se) begin
                m_para = SYNC;
                if (pout == SYNC) m_match = m_match + 1;
                else              m_match = 0;
                if (m_match == LOCK_COUNT) begin
                    m_run = 1; m_locked = 1; m_match = 0; m_data = 0;
                end
            end
        end else if (se) begin
            if (m_data == SYNC_PERIOD) begin
                m_para = SYNC; m_data = 0;
            end else if (g >= 0) begin
                m_para = gbyte; m_grant = g; m_rr = (g + 1) % NREQ; m_data = m_data + 1;
            end else begin
                m_para = IDLE;
            end
        end
        m_slot = (m_slot + 1) % HOLD;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; retrain = 1'b0; req_valid = '0; req_data = '0; para_out_i = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_lock();
        do_reset();
        para_out_i = SYNC;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        req_valid = '1; req_data = {8'hC3, 8'h3C, 8'hA5}; retrain = 1'b0; para_out_i = SYNC;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (para_in_o !== 8'h00) $display("FAIL reset_para_in got %h exp 00", para_in_o); else n_pass++;
        n_checks++; if (req_ready !== '0) $display("FAIL reset_req_ready got %b exp 000", req_ready); else n_pass++;
        n_checks++; if (grant_id !== 3'd0) $display("FAIL reset_grant_id got %0d exp 0", grant_id); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %b exp 0", locked); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else n_pass++;
        n_checks++; if (rx_is_sync !== 1'b0) $display("FAIL reset_rx_is_sync got %b exp 0", rx_is_sync); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            n_checks++;
            if (para_in_o !== ((e >= 4) ? SYNC : IDLE))
                $display("FAIL hold_para_in edge %0d got %h exp %h", e, para_in_o, (e >= 4) ? SYNC : IDLE);
            else n_pass++;
            n_checks++;
            if (locked !== (e >= 12)) $display("FAIL hold_locked edge %0d got %b exp %b", e, locked, (e >= 12));
            else n_pass++;
            if (e <= 12) begin
                n_checks++; if (obs_ready !== '0) $display("FAIL train_req_ready cycle %0d got %b exp 000", e, obs_ready); else n_pass++;
                n_checks++; if (rx_valid !== 1'b0) $display("FAIL train_rx_valid edge %0d got %b exp 0", e, rx_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_train_miss();
        logic [7:0] pat [6];
        pat = '{8'h81, 8'h81, 8'h00, 8'h81, 8'h81, 8'h81};
        do_reset();
        req_valid = '1;
        for (int e = 1; e <= 26; e++) begin
            para_out_i = ((e - 1) / 4 < 6) ? pat[(e - 1) / 4] : SYNC;
            tick();
            n_checks++;
            if (locked !== (e >= 24)) $display("FAIL miss_locked edge %0d got %b exp %b", e, locked, (e >= 24));
            else n_pass++;
            n_checks++;
            if (obs_ready !== e_ready) $display("FAIL miss_req_ready cycle %0d got %b exp %b", e, obs_ready, e_ready);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]      exp_slot [10];
        logic [NREQ-1:0] exp_rdy  [10];
        int              exp_gnt  [10];
        int              k;
        exp_slot = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h81, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h81};
        exp_rdy  = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b001, 3'b010, 3'b000};
        exp_gnt  = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
        do_lock();
        req_data = {8'h77, 8'h3C, 8'hA5};
        req_valid = 3'b011;
        for (int e = 1; e <= 40; e++) begin
            para_out_i = para_in_o;
            tick();
            n_checks++;
            if (obs_ready !== e_ready) $display("FAIL rr_req_ready_model cycle %0d got %b exp %b", e, obs_ready, e_ready);
            else n_pass++;
            if (e % 4 == 0) begin
                k = e / 4 - 1;
                n_checks++;
                if (para_in_o !== exp_slot[k]) $display("FAIL rr_slot %0d got %h exp %h", k, para_in_o, exp_slot[k]);
                else n_pass++;
                n_checks++;
                if (obs_ready !== exp_rdy[k]) $display("FAIL rr_req_ready slot %0d got %b exp %b", k, obs_ready, exp_rdy[k]);
                else n_pass++;
                n_checks++;
                if (grant_id !== 3'(exp_gnt[k])) $display("FAIL rr_grant_id slot %0d got %0d exp %0d", k, grant_id, exp_gnt[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sync_insert();
        logic [7:0] exp_slot [10];
        logic [7:0] exp_rx;
        int         k;
        exp_slot = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h81, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h81};
        do_lock();
        req_data = {8'h5A, 8'h00, 8'h00};
        req_valid = 3'b100;
        for (int e = 1; e <= 40; e++) begin
            para_out_i = para_in_o;
            tick();
            n_checks++;
            if (rx_valid !== (e % 4 == 0)) $display("FAIL sync_rx_valid edge %0d got %b exp %b", e, rx_valid, (e % 4 == 0));
            else n_pass++;
            if (e % 4 == 0) begin
                k = e / 4 - 1;
                exp_rx = (k == 0) ? SYNC : exp_slot[k - 1];
                n_checks++;
                if (para_in_o !== exp_slot[k]) $display("FAIL sync_slot %0d got %h exp %h", k, para_in_o, exp_slot[k]);
                else n_pass++;
                n_checks++;
                if (obs_ready !== ((exp_slot[k] == SYNC) ? 3'b000 : 3'b100))
                    $display("FAIL sync_req_ready slot %0d got %b exp %b", k, obs_ready, (exp_slot[k] == SYNC) ? 3'b000 : 3'b100);
                else n_pass++;
                n_checks++;
                if (rx_data !== exp_rx) $display("FAIL sync_rx_data slot %0d got %h exp %h", k, rx_data, exp_rx);
                else n_pass++;
                n_checks++;
                if (rx_is_sync !== (exp_rx == SYNC)) $display("FAIL sync_rx_is_sync slot %0d got %b exp %b", k, rx_is_sync, (exp_rx == SYNC));
                else n_pass++;
            end
        end
    endtask

    task automatic test_idle_rx();
        bit         on  [9];
        logic [7:0] exp [9];
        int         k;
        on  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        exp = '{8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h81, 8'h11};
        do_lock();
        req_data = {8'h00, 8'h00, 8'h11};
        for (int e = 1; e <= 36; e++) begin
            req_valid  = on[(e - 1) / 4] ? 3'b001 : 3'b000;
            para_out_i = 8'($urandom_range(0, 255));
            tick();
            n_checks++;
            if (rx_valid !== (e % 4 == 0)) $display("FAIL idle_rx_valid edge %0d got %b exp %b", e, rx_valid, (e % 4 == 0));
            else n_pass++;
            n_checks++;
            if (obs_ready !== e_ready) $display("FAIL idle_req_ready cycle %0d got %b exp %b", e, obs_ready, e_ready);
            else n_pass++;
            if (e % 4 == 0) begin
                k = e / 4 - 1;
                n_checks++;
                if (para_in_o !== exp[k]) $display("FAIL idle_slot %0d got %h exp %h", k, para_in_o, exp[k]);
                else n_pass++;
                n_checks++;
                if (rx_data !== m_rxd) $display("FAIL idle_rx_data slot %0d got %h exp %h", k, rx_data, m_rxd);
                else n_pass++;
                n_checks++;
                if (rx_is_sync !== m_rxs) $display("FAIL idle_rx_is_sync slot %0d got %b exp %b", k, rx_is_sync, m_rxs);
                else n_pass++;
            end
        end
    endtask

    task automatic test_retrain();
        logic [7:0] exp_p;
        bit         exp_l;
        do_lock();
        req_data = {8'hC3, 8'h3C, 8'hA5};
        req_valid = '1;
        for (int e = 1; e <= 28; e++) begin
            retrain    = (e == 8) || (e == 26);
            para_out_i = para_in_o;
            tick();
            if (e < 4)       exp_p = SYNC;
            else if (e < 8)  exp_p = 8'hA5;
            else if (e < 24) exp_p = SYNC;
            else if (e < 28) exp_p = 8'h3C;
            else             exp_p = SYNC;
            exp_l = (e < 8) || ((e >= 20) && (e < 26));
            n_checks++;
            if (para_in_o !== exp_p) $display("FAIL retrain_para_in edge %0d got %h exp %h", e, para_in_o, exp_p);
            else n_pass++;
            n_checks++;
            if (locked !== exp_l) $display("FAIL retrain_locked edge %0d got %b exp %b", e, locked, exp_l);
            else n_pass++;
            if (e == 8) begin
                n_checks++;
                if (obs_ready !== 3'b000) $display("FAIL retrain_req_ready got %b exp 000", obs_ready);
                else n_pass++;
            end
        end
        retrain = 1'b0;
    endtask

    task automatic test_async_reset();
        do_lock();
        req_data = {8'hC3, 8'h3C, 8'hA5};
        req_valid = '1;
        for (int e = 1; e <= 6; e++) begin
            para_out_i = para_in_o;
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (para_in_o !== 8'h00) $display("FAIL areset_para_in got %h exp 00", para_in_o); else n_pass++;
        n_checks++; if (req_ready !== '0) $display("FAIL areset_req_ready got %b exp 000", req_ready); else n_pass++;
        n_checks++; if (grant_id !== 3'd0) $display("FAIL areset_grant_id got %0d exp 0", grant_id); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL areset_locked got %b exp 0", locked); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL areset_rx_valid got %b exp 0", rx_valid); else n_pass++;
        n_checks++; if (rx_is_sync !== 1'b0) $display("FAIL areset_rx_is_sync got %b exp 0", rx_is_sync); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL areset_rx_data got %h exp 00", rx_data); else n_pass++;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            para_out_i = SYNC;
            tick();
            n_checks++;
            if (para_in_o !== 8'h00) $display("FAIL areset_restart_para_in edge %0d got %h exp 00", e, para_in_o);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (obs_ready[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[8*i +: 8] = 8'($urandom_range(0, 255));
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            case ($urandom_range(0, 9))
                0:       para_out_i = 8'($urandom_range(0, 255));
                1:       para_out_i = SYNC;
                default: para_out_i = para_in_o;
            endcase
            retrain = ($urandom_range(0, 79) == 0);
            tick();
            n_checks++; if (obs_ready !== e_ready) $display("FAIL rnd_req_ready t=%0d got %b exp %b", t, obs_ready, e_ready); else n_pass++;
            n_checks++; if (para_in_o !== m_para) $display("FAIL rnd_para_in t=%0d got %h exp %h", t, para_in_o, m_para); else n_pass++;
            n_checks++; if (grant_id !== 3'(m_grant)) $display("FAIL rnd_grant_id t=%0d got %0d exp %0d", t, grant_id, m_grant); else n_pass++;
            n_checks++; if (locked !== m_locked) $display("FAIL rnd_locked t=%0d got %b exp %b", t, locked, m_locked); else n_pass++;
            n_checks++; if (rx_valid !== m_rxv) $display("FAIL rnd_rx_valid t=%0d got %b exp %b", t, rx_valid, m_rxv); else n_pass++;
            n_checks++; if (rx_data !== m_rxd) $display("FAIL rnd_rx_data t=%0d got %h exp %h", t, rx_data, m_rxd); else n_pass++;
            n_checks++; if (rx_is_sync !== m_rxs) $display("FAIL rnd_rx_is_sync t=%0d got %b exp %b", t, rx_is_sync, m_rxs); else n_pass++;
        end
        retrain = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        retrain    = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        para_out_i = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_train_miss();
        test_round_robin();
        test_sync_insert();
        test_idle_rx();
        test_retrain();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
